// File: rtl/io_port_bridge_if.sv
// Host/core side signal bundle for io_port_bridge.
// The bridge uses the slave view; whoever drives the host byte stream, the
// core output port and the TX drain uses the master view.
`timescale 1ns/1ps

interface io_port_bridge_if;
  // host -> core byte stream
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  // core-facing input port and its interrupt
  logic [7:0] I_Port;
  logic       int_sig;
  // core output port captured by the bridge
  logic [7:0] O_Port;
  // core -> host drain
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  // overflow status
  logic       tx_overflow;
  logic       clr_ovf;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output I_Port,
    output int_sig,
    input  O_Port,
    output out_data,
    output out_valid,
    input  out_ready,
    output tx_overflow,
    input  clr_ovf
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  I_Port,
    input  int_sig,
    output O_Port,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  tx_overflow,
    output clr_ovf
  );
endinterface

// File: rtl/io_port_bridge.sv
// Board-side peripheral for the CPU wrapper's I/O pins.
// RX path: host bytes are buffered and presented one at a time on I_Port,
// each with a one-cycle int_sig pulse followed by a guaranteed hold window.
// TX path: every change on the core's O_Port is captured into a FIFO that the
// host drains with a valid/ready handshake; dropped captures set a sticky flag.
`timescale 1ns/1ps

module io_port_bridge #(
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4,
  parameter int HOLD     = 16
) (
  input  logic             clk,
  input  logic             rst,
  io_port_bridge_if.slave  bus
);

  localparam int RX_AW  = $clog2(RX_DEPTH);
  localparam int TX_AW  = $clog2(TX_DEPTH);
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [RX_AW:0]    RX_FULL     = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [RX_AW:0]    RX_CNT_ZERO = (RX_AW + 1)'(0);
  localparam logic [RX_AW:0]    RX_CNT_ONE  = (RX_AW + 1)'(1);
  localparam logic [RX_AW-1:0]  RX_PTR_ZERO = RX_AW'(0);
  localparam logic [RX_AW-1:0]  RX_PTR_ONE  = RX_AW'(1);

  localparam logic [TX_AW:0]    TX_FULL     = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [TX_AW:0]    TX_CNT_ZERO = (TX_AW + 1)'(0);
  localparam logic [TX_AW:0]    TX_CNT_ONE  = (TX_AW + 1)'(1);
  localparam logic [TX_AW-1:0]  TX_PTR_ZERO = TX_AW'(0);
  localparam logic [TX_AW-1:0]  TX_PTR_ONE  = TX_AW'(1);

  localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO   = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IRQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // RX FIFO storage and bookkeeping
  logic [7:0]       rx_mem_r [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr_r;
  logic [RX_AW-1:0] rx_rd_ptr_r;
  logic [RX_AW:0]   rx_count_r;
  logic             rx_full_s;
  logic             rx_empty_s;
  logic             rx_push_s;
  logic             rx_pop_s;

  // presenter
  state_t           state_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [7:0]       i_port_r;
  logic             int_sig_r;

  // TX FIFO storage and bookkeeping
  logic [7:0]       tx_mem_r [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr_r;
  logic [TX_AW-1:0] tx_rd_ptr_r;
  logic [TX_AW:0]   tx_count_r;
  logic             tx_full_s;
  logic             tx_empty_s;
  logic             tx_push_s;
  logic             tx_pop_s;

  // output capture
  logic [7:0]       o_last_r;
  logic             capture_s;
  logic             tx_drop_s;
  logic             tx_overflow_r;

  // Handshake decisions; status flags come only from counts so there is no
  // combinational path from in_valid/out_ready to in_ready/out_valid.
  always_comb begin
    rx_full_s  = (rx_count_r == RX_FULL);
    rx_empty_s = (rx_count_r == RX_CNT_ZERO);
    rx_push_s  = bus.in_valid && !rx_full_s;
    rx_pop_s   = (state_r == ST_IDLE) && !rx_empty_s;

    tx_full_s  = (tx_count_r == TX_FULL);
    tx_empty_s = (tx_count_r == TX_CNT_ZERO);
    capture_s  = (bus.O_Port != o_last_r);
    tx_pop_s   = bus.out_ready && !tx_empty_s;
    // A full FIFO still accepts a capture when the host frees a slot this cycle.
    tx_push_s  = capture_s && (!tx_full_s || tx_pop_s);
    tx_drop_s  = capture_s && tx_full_s && !tx_pop_s;
  end

  // RX FIFO: circular buffer, simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RX_DEPTH; i++) begin
        rx_mem_r[i] <= 8'h00;
      end
      rx_wr_ptr_r <= RX_PTR_ZERO;
      rx_rd_ptr_r <= RX_PTR_ZERO;
      rx_count_r  <= RX_CNT_ZERO;
    end else begin
      if (rx_push_s) begin
        rx_mem_r[rx_wr_ptr_r] <= bus.in_data;
        rx_wr_ptr_r           <= rx_wr_ptr_r + RX_PTR_ONE;
      end
      if (rx_pop_s) begin
        rx_rd_ptr_r <= rx_rd_ptr_r + RX_PTR_ONE;
      end
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_count_r <= rx_count_r + RX_CNT_ONE;
        2'b01:   rx_count_r <= rx_count_r - RX_CNT_ONE;
        default: rx_count_r <= rx_count_r;
      endcase
    end
  end

  // Presenter: pop a byte onto I_Port, pulse int_sig for one cycle, then hold
  // the byte for HOLD cycles before the next pop (HOLD+2 cycles per byte).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= HOLD_ZERO;
      i_port_r   <= 8'h00;
      int_sig_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rx_pop_s) begin
            i_port_r  <= rx_mem_r[rx_rd_ptr_r];
            int_sig_r <= 1'b1;
            state_r   <= ST_IRQ;
          end else begin
            int_sig_r <= 1'b0;
          end
        end
        ST_IRQ: begin
          int_sig_r  <= 1'b0;
          hold_cnt_r <= HOLD_LOAD;
          state_r    <= ST_HOLD;
        end
        ST_HOLD: begin
          int_sig_r <= 1'b0;
          if (hold_cnt_r == HOLD_ZERO) begin
            state_r <= ST_IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r - HOLD_ONE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          hold_cnt_r <= HOLD_ZERO;
          int_sig_r  <= 1'b0;
        end
      endcase
    end
  end

  // Change detector: o_last follows O_Port even when the capture is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_last_r <= 8'h00;
    end else if (capture_s) begin
      o_last_r <= bus.O_Port;
    end else begin
      o_last_r <= o_last_r;
    end
  end

  // TX FIFO: circular buffer fed by the change detector, drained by the host.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TX_DEPTH; i++) begin
        tx_mem_r[i] <= 8'h00;
      end
      tx_wr_ptr_r <= TX_PTR_ZERO;
      tx_rd_ptr_r <= TX_PTR_ZERO;
      tx_count_r  <= TX_CNT_ZERO;
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wr_ptr_r] <= bus.O_Port;
        tx_wr_ptr_r           <= tx_wr_ptr_r + TX_PTR_ONE;
      end
      if (tx_pop_s) begin
        tx_rd_ptr_r <= tx_rd_ptr_r + TX_PTR_ONE;
      end
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_count_r <= tx_count_r + TX_CNT_ONE;
        2'b01:   tx_count_r <= tx_count_r - TX_CNT_ONE;
        default: tx_count_r <= tx_count_r;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle beats a clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_overflow_r <= 1'b0;
    end else if (tx_drop_s) begin
      tx_overflow_r <= 1'b1;
    end else if (bus.clr_ovf) begin
      tx_overflow_r <= 1'b0;
    end else begin
      tx_overflow_r <= tx_overflow_r;
    end
  end

  assign bus.in_ready    = !rx_full_s;
  assign bus.I_Port      = i_port_r;
  assign bus.int_sig     = int_sig_r;
  assign bus.out_valid   = !tx_empty_s;
  assign bus.out_data    = tx_mem_r[tx_rd_ptr_r];
  assign bus.tx_overflow = tx_overflow_r;

endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge: directed scenarios plus a random
// phase, all compared every cycle against a queue-based reference model.
`timescale 1ns/1ps

module tb_io_port_bridge;
  localparam int RX_DEPTH = 4;
  localparam int TX_DEPTH = 4;
  localparam int HOLD     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  io_port_bridge_if bus();

  io_port_bridge #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reference model state
  logic [7:0] m_rx_q[$];
  logic [7:0] m_tx_q[$];
  logic [7:0] m_iport;
  logic [7:0] m_olast;
  logic       m_int;
  logic       m_ovf;
  logic       m_acc;
  int         m_next_free;

  // observation records
  logic [7:0] popped[$];
  logic [7:0] pulse_val[$];
  int         pulse_cyc[$];
  logic       last_ov;
  logic [7:0] last_od;
  logic       saw_full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_rx_q.delete();
    m_tx_q.delete();
    m_iport     = 8'h00;
    m_olast     = 8'h00;
    m_int       = 1'b0;
    m_ovf       = 1'b0;
    m_acc       = 1'b0;
    m_next_free = cyc;
  endtask

  // One clock edge of the behavioural model, using the inputs seen at the edge.
  task automatic model_edge();
    bit do_pop;
    bit t_pop;
    bit t_full;
    bit capture;
    // RX: presenter is busy for HOLD+2 cycles after each presented byte.
    m_int  = 1'b0;
    m_acc  = bus.in_valid && (m_rx_q.size() < RX_DEPTH);
    do_pop = (m_rx_q.size() > 0) && (cyc >= m_next_free);
    if (do_pop) begin
      m_iport     = m_rx_q.pop_front();
      m_int       = 1'b1;
      m_next_free = cyc + HOLD + 2;
    end
    if (m_acc) m_rx_q.push_back(bus.in_data);
    // TX: change capture into a bounded queue.
    if (last_ov && bus.out_ready) popped.push_back(last_od);
    t_pop   = bus.out_ready && (m_tx_q.size() > 0);
    t_full  = (m_tx_q.size() == TX_DEPTH);
    capture = (bus.O_Port != m_olast);
    if (t_pop) void'(m_tx_q.pop_front());
    if (capture) begin
      m_olast = bus.O_Port;
      if (!t_full || t_pop) m_tx_q.push_back(bus.O_Port);
    end
    if (capture && t_full && !t_pop) m_ovf = 1'b1;
    else if (bus.clr_ovf) m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    chk("I_Port", bus.I_Port, m_iport);
    chk("int_sig", bus.int_sig, m_int);
    chk("in_ready", bus.in_ready, (m_rx_q.size() < RX_DEPTH));
    chk("out_valid", bus.out_valid, (m_tx_q.size() > 0));
    chk("tx_overflow", bus.tx_overflow, m_ovf);
    if (m_tx_q.size() > 0) chk("out_data", bus.out_data, m_tx_q[0]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      cyc++;
      model_edge();
    end
    #1;
    if (!rst) check_outputs();
    last_ov = bus.out_valid;
    last_od = bus.out_data;
    if (bus.int_sig) begin
      pulse_cyc.push_back(cyc);
      pulse_val.push_back(bus.I_Port);
    end
    if (!bus.in_ready) saw_full = 1'b1;
  endtask

  task automatic push_rx(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    m_acc        = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (m_acc) break;
    end
    chk("rx_push_accepted", m_acc, 1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    logic [7:0] exp_b[$];

    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.O_Port    = 8'h00;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    last_ov       = 1'b0;
    last_od       = 8'h00;
    saw_full      = 1'b0;

    // ---- reset state
    rst = 1'b1;
    #12;
    chk("rst_I_Port", bus.I_Port, 8'h00);
    chk("rst_int_sig", bus.int_sig, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 8'h00);
    chk("rst_tx_overflow", bus.tx_overflow, 1'b0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) tick();
    chk("o_port_zero_no_push", bus.out_valid, 1'b0);

    // ---- single RX byte, held with no further pulses
    pulse_cyc.delete(); pulse_val.delete();
    push_rx(8'hA5);
    e0 = cyc;
    for (int i = 0; i < 1000; i++) tick();
    chk("single_pulse_count", pulse_cyc.size(), 1);
    if (pulse_cyc.size() > 0) begin
      chk("single_pulse_cycle", pulse_cyc[0], e0 + 1);
      chk("single_pulse_byte", pulse_val[0], 8'hA5);
    end
    chk("single_hold", bus.I_Port, 8'hA5);

    // ---- RX burst: FIFO fills, bytes in order, HOLD+2 spacing
    pulse_cyc.delete(); pulse_val.delete();
    saw_full = 1'b0;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (exp_b[k]) push_rx(exp_b[k]);
    for (int i = 0; i < 400; i++) begin
      if (pulse_cyc.size() >= 6) break;
      tick();
    end
    chk("burst_in_ready_dropped", saw_full, 1'b1);
    chk("burst_pulse_count", pulse_cyc.size(), 6);
    if (pulse_cyc.size() == 6) begin
      foreach (exp_b[k]) chk("burst_order", pulse_val[k], exp_b[k]);
      for (int k = 1; k < 6; k++) chk("burst_gap", pulse_cyc[k] - pulse_cyc[k-1], HOLD + 2);
    end

    // ---- TX capture with repeated value
    popped.delete();
    bus.out_ready = 1'b1;
    bus.O_Port = 8'h01; tick();
    bus.O_Port = 8'h01; tick();
    bus.O_Port = 8'hF6; tick();
    for (int i = 0; i < 4; i++) tick();
    chk("tx_capture_count", popped.size(), 2);
    if (popped.size() == 2) begin
      chk("tx_capture_0", popped[0], 8'h01);
      chk("tx_capture_1", popped[1], 8'hF6);
    end

    // ---- TX overflow, clear, full+pop capture
    popped.delete();
    bus.out_ready = 1'b0;
    for (int v = 8'h10; v <= 8'h14; v++) begin
      bus.O_Port = 8'(v);
      tick();
    end
    tick();
    chk("ovf_set", bus.tx_overflow, 1'b1);
    chk("ovf_head", bus.out_data, 8'h10);
    bus.clr_ovf = 1'b1; tick();
    bus.clr_ovf = 1'b0;
    chk("ovf_cleared", bus.tx_overflow, 1'b0);
    bus.O_Port = 8'h20; bus.out_ready = 1'b1; tick();
    chk("ovf_full_pop_no_set", bus.tx_overflow, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    bus.out_ready = 1'b0;
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
    chk("ovf_drain_count", popped.size(), 5);
    if (popped.size() == 5) begin
      foreach (exp_b[k]) chk("ovf_drain", popped[k], exp_b[k]);
    end

    // ---- randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      bus.in_valid  = ($urandom_range(0, 2) == 0);
      bus.in_data   = 8'($urandom);
      if ($urandom_range(0, 2) == 0) bus.O_Port = 8'($urandom_range(0, 7));
      bus.out_ready = ($urandom_range(0, 3) == 0) || (i > 400 && $urandom_range(0, 1) == 0);
      bus.clr_ovf   = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.clr_ovf  = 1'b0;
    bus.O_Port   = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (m_rx_q.size() == 0 && cyc >= m_next_free) break;
      tick();
    end
    chk("random_rx_drained", (m_rx_q.size() == 0 && cyc >= m_next_free), 1'b1);

    // ---- reset during HOLD with two bytes queued
    pulse_cyc.delete(); pulse_val.delete();
    push_rx(8'hA1);
    push_rx(8'hB2);
    push_rx(8'hC3);
    for (int i = 0; i < 20; i++) begin
      if (pulse_cyc.size() > 0) break;
      tick();
    end
    chk("midrst_first_pulse", pulse_cyc.size(), 1);
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_before", bus.I_Port, 8'hA1);
    rst = 1'b1;
    #2;
    chk("midrst_I_Port", bus.I_Port, 8'h00);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_int_sig", bus.int_sig, 1'b0);
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    pulse_cyc.delete(); pulse_val.delete();
    for (int i = 0; i < 60; i++) tick();
    chk("midrst_no_pulse", pulse_cyc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
